stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Run/pause/clear controller that sequences the 3-digit BCD counter and its 7-segment display register as a stopwatch. It derives count ticks from `clk` with a prescaler and drives the counter's increment enable and clear. It stops the count at a programmable BCD limit and raises an alarm. A lap function freezes the display register while counting continues.

## Interface
- `PRESCALE`, default 1000: `clk` cycles per count tick; legal range ≥1.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high; resets every register in the block.
- `start_stop` in 1: level button; a rising edge toggles run/pause. Synchronous to `clk`, debounced upstream.
- `clear` in 1: level button; a rising edge clears the count.
- `lap` in 1: level button; a rising edge toggles display hold while running.
- `limit_en` in 1: enables terminal-count detection.
- `limit` in 12: BCD limit, {hundreds, tens, units}.
- `cnt_bcd` in 12: current counter value, same digit order as `limit`.
- `cnt_en` out 1: one-cycle increment pulse to the counter.
- `cnt_clr` out 1: one-cycle synchronous clear pulse to the counter.
- `hold` out 1: when 1, the display register keeps its value.
- `alarm` out 1: high while in DONE.
- `state` out 2: IDLE=0, RUN=1, PAUSE=2, DONE=3.

## Operation
- Edge detect: `rise_x = x & ~x_q`, where `x_q` is the input registered each cycle. `x_q` resets to 1, so a button already held during reset does not fire.
- Prescaler `pre`:
  - width max(1, clog2(PRESCALE)); counts 0..PRESCALE-1 and wraps to 0.
  - advances only in RUN; keeps its value in PAUSE; zeroed on entry to IDLE or DONE and on reset.
- `match = limit_en & (cnt_bcd == limit)`. A non-BCD `limit` value never matches.
- Transitions are evaluated once per edge. Priority: `clear` > `match` > `start_stop` > `lap`.
  - IDLE: `rise_start_stop` → RUN. `rise_clear` → pulse `cnt_clr`, stay in IDLE.
  - RUN:
    - `rise_clear` → pulse `cnt_clr`, go to IDLE.
    - else `match` → DONE.
    - else `rise_start_stop` → PAUSE.
    - else `rise_lap` → toggle `hold`.
  - PAUSE: `rise_clear` → pulse `cnt_clr`, go to IDLE. `rise_start_stop` → RUN. `lap` is ignored.
  - DONE: `rise_clear` or `rise_start_stop` → pulse `cnt_clr`, go to IDLE.
- `cnt_en = (state==RUN) & (pre==PRESCALE-1) & ~match`. It is combinational from registers, and `~match` prevents overshoot past the limit.
- `hold` is cleared on entry to IDLE and on entry to DONE. It is kept through PAUSE.
- `alarm = (state==DONE)`.
- `cnt_clr` is registered and is high exactly one cycle after the qualifying edge.

## Timing
- Reset values: `state`=IDLE, `pre`=0, `cnt_en`=0, `cnt_clr`=0, `hold`=0, `alarm`=0.
- Button response:
  - A button level seen high at edge N, and low at edge N-1, changes `state` at edge N.
  - `cnt_clr` is high during cycle N..N+1.
- Tick timing:
  - The first `cnt_en` is high in the PRESCALE-th cycle after entering RUN. After that it repeats every PRESCALE cycles.
  - With PRESCALE=1, `cnt_en` is high every RUN cycle.
- Counter latency: the counter increments at the edge that samples `cnt_en`=1, so the new `cnt_bcd` is visible one cycle later. `match` sees the new `cnt_bcd` that same cycle, and DONE is entered at the following edge.
- Pause/resume: the prescaler phase is preserved. The total RUN cycles between ticks equal PRESCALE, regardless of PAUSE length.
- Limit boundaries:
  - `limit`=000 with `limit_en`=1 enters DONE one edge after RUN is entered, with no ticks issued.
  - The counter wrapping 999→000 is normal when `limit_en`=0.
- Reset mid-operation: everything returns to the reset values at that edge. No `cnt_clr` pulse is produced, because the counter has its own reset.

## Structure
- Shared package/include:
  - state encodings (IDLE/RUN/PAUSE/DONE, 2-bit);
  - BCD digit width constant (4);
  - counter width constant (12).
- Sub-module `edge_rise`: 1-bit registered rising-edge detector with reset value 1. It is instantiated three times (start_stop, clear, lap).
- The FSM, prescaler and output logic stay in `stopwatch_ctrl`.

## Test plan
- PRESCALE=4; pulse `start_stop`; emulate the counter → `cnt_en` high at cycles 4, 8, 12 after entry; `cnt_bcd` reaches 003.
- From RUN with `pre`=2, pause for 10 cycles, then resume → next `cnt_en` 1 cycle after resume (phase kept).
- `limit`=005, `limit_en`=1 → exactly 5 `cnt_en` pulses; `state`=DONE and `alarm`=1 one edge after `cnt_bcd`=005; no 6th pulse.
- `lap` rise in RUN → `hold`=1 while `cnt_en` continues; second `lap` rise → `hold`=0. `lap` in PAUSE → no change.
- `clear` and `start_stop` rise on the same edge in RUN → IDLE, single-cycle `cnt_clr`, `hold`=0.
- `start_stop` held high through reset release → stays IDLE; reset asserted mid-RUN → all outputs 0 and IDLE at that edge.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and widths for the stopwatch controller.
// State encoding plus BCD digit and counter widths.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } sw_state_e;

    localparam int DIGIT_W = 4;
    localparam int CNT_W   = 3 * DIGIT_W;

endpackage

// File: rtl/stopwatch_ctrl_edge_rise.sv
// Registered rising-edge detector for a level button.
// Ports: clk, reset, x (level in), rise (one-cycle pulse out).
module edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic rise
);

    logic x_q;

    // Reset to 1 so a button held through reset does not fire.
    always_ff @(posedge clk) begin
        if (reset) x_q <= 1'b1;
        else       x_q <= x;
    end

    assign rise = x & ~x_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear/lap controller for a 3-digit BCD counter.
// Ports: clk, reset, start_stop, clear, lap, limit_en, limit[11:0],
//        cnt_bcd[11:0] in; cnt_en, cnt_clr, hold, alarm, state[1:0] out.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int PRESCALE = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             lap,
    input  logic             limit_en,
    input  logic [CNT_W-1:0] limit,
    input  logic [CNT_W-1:0] cnt_bcd,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             hold,
    output logic             alarm,
    output logic [1:0]       state
);

    localparam int PW =
        (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX =
        PW'(PRESCALE - 1);

    sw_state_e     st_q, st_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          hold_q, hold_d;
    logic          clr_q, clr_d;

    logic rise_ss, rise_clr, rise_lap;
    logic match, tick;

    edge_rise u_ss (
        .clk   (clk),
        .reset (reset),
        .x     (start_stop),
        .rise  (rise_ss)
    );

    edge_rise u_clr (
        .clk   (clk),
        .reset (reset),
        .x     (clear),
        .rise  (rise_clr)
    );

    edge_rise u_lap (
        .clk   (clk),
        .reset (reset),
        .x     (lap),
        .rise  (rise_lap)
    );

    // cnt_bcd is always valid BCD, so a non-BCD limit never matches.
    assign match = limit_en & (cnt_bcd == limit);
    assign tick  = (st_q == RUN) & (pre_q == PRE_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= IDLE;
            pre_q  <= '0;
            hold_q <= 1'b0;
            clr_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            pre_q  <= pre_d;
            hold_q <= hold_d;
            clr_q  <= clr_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        pre_d  = pre_q;
        hold_d = hold_q;
        clr_d  = 1'b0;

        if (st_q == RUN)
            pre_d = tick ? '0 : pre_q + 1'b1;

        unique case (st_q)
            IDLE: begin
                if (rise_clr)     clr_d = 1'b1;
                else if (rise_ss) st_d  = RUN;
            end
            RUN: begin
                if (rise_clr) begin
                    clr_d = 1'b1;
                    st_d  = IDLE;
                end else if (match) begin
                    st_d = DONE;
                end else if (rise_ss) begin
                    st_d = PAUSE;
                end else if (rise_lap) begin
                    hold_d = ~hold_q;
                end
            end
            PAUSE: begin
                if (rise_clr) begin
                    clr_d = 1'b1;
                    st_d  = IDLE;
                end else if (rise_ss) begin
                    st_d = RUN;
                end
            end
            DONE: begin
                if (rise_clr | rise_ss) begin
                    clr_d = 1'b1;
                    st_d  = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase

        // Resting states restart the tick phase and release the display.
        if (st_d == IDLE || st_d == DONE) begin
            pre_d  = '0;
            hold_d = 1'b0;
        end
    end

    // ~match keeps the counter from stepping past the limit.
    assign cnt_en  = tick & ~match;
    assign cnt_clr = clr_q;
    assign hold    = hold_q;
    assign alarm   = (st_q == DONE);
    assign state   = st_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with an emulated BCD counter.
// Directed steps then random buttons against a reference model.
module tb_stopwatch_ctrl;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic        limit_en = 1'b0;
    logic [11:0] limit = 12'h000;
    logic [11:0] cnt_bcd;
    logic        cnt_en, cnt_clr, hold, alarm;
    logic [1:0]  state;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.PRESCALE(P)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .limit_en   (limit_en),
        .limit      (limit),
        .cnt_bcd    (cnt_bcd),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .hold       (hold),
        .alarm      (alarm),
        .state      (state)
    );

    function automatic logic [11:0] to_bcd(int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    function automatic int from_bcd(logic [11:0] b);
        if (b[11:8] > 9 || b[7:4] > 9 || b[3:0] > 9)
            return -1;
        return b[11:8] * 100 + b[7:4] * 10 + b[3:0];
    endfunction

    // Counter emulation (decimal value, shown as BCD).
    int cnt_val = 0;
    assign cnt_bcd = to_bcd(cnt_val);

    // Reference model: state name code, RUN cycles since last restart.
    int m_st = 0;
    int m_runs = 0;
    bit m_hold = 0;
    bit m_clr = 0;
    bit p_ss = 1, p_clr = 1, p_lap = 1;

    int passed = 0;
    int fails = 0;
    int total = 0;
    int en_count = 0;

    task automatic chk(string tag, logic [11:0] obs,
                       logic [11:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit rs, rc, rl, mt, d_en, d_clr;
        int lim, n_st, n_runs;
        bit n_hold, n_clr;
        #1;
        lim = from_bcd(limit);
        mt  = limit_en && (lim == cnt_val);
        chk("state", 12'(state), 12'(m_st));
        chk("cnt_en", 12'(cnt_en),
            12'(m_st == 1 && (m_runs % P) == P - 1 && !mt));
        chk("cnt_clr", 12'(cnt_clr), 12'(m_clr));
        chk("hold", 12'(hold), 12'(m_hold));
        chk("alarm", 12'(alarm), 12'(m_st == 3));
        d_en  = cnt_en;
        d_clr = cnt_clr;
        if (cnt_en === 1'b1) en_count++;

        rs = start_stop && !p_ss;
        rc = clear && !p_clr;
        rl = lap && !p_lap;
        n_st = m_st; n_runs = m_runs;
        n_hold = m_hold; n_clr = 0;
        if (reset) begin
            n_st = 0; n_runs = 0; n_hold = 0;
        end else begin
            case (m_st)
                0: if (rc) n_clr = 1;
                   else if (rs) n_st = 1;
                1: begin
                    n_runs = m_runs + 1;
                    if (rc) begin n_clr = 1; n_st = 0; end
                    else if (mt) n_st = 3;
                    else if (rs) n_st = 2;
                    else if (rl) n_hold = !m_hold;
                end
                2: if (rc) begin n_clr = 1; n_st = 0; end
                   else if (rs) n_st = 1;
                default: if (rc || rs) begin
                    n_clr = 1; n_st = 0;
                end
            endcase
            if (n_st == 0 || n_st == 3) begin
                n_runs = 0; n_hold = 0;
            end
        end

        @(posedge clk);
        #1;
        if (reset) begin
            p_ss = 1; p_clr = 1; p_lap = 1;
            cnt_val = 0;
        end else begin
            p_ss = start_stop; p_clr = clear; p_lap = lap;
            if (d_clr) cnt_val = 0;
            else if (d_en) cnt_val = (cnt_val + 1) % 1000;
        end
        m_st = n_st; m_runs = n_runs;
        m_hold = n_hold; m_clr = n_clr;
        @(negedge clk);
    endtask

    task automatic press_ss();
        start_stop = 1'b1;
        tick();
        start_stop = 1'b0;
        tick();
    endtask

    initial begin
        int e0;
        start_stop = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        #1 chk("held_through_reset", 12'(state), 12'd0);
        start_stop = 1'b0;
        tick();

        // Ticks at RUN cycles 4, 8, 12.
        en_count = 0;
        press_ss();
        repeat (11) tick();
        #1 chk("ticks_12cyc", 12'(en_count), 12'd3);
        chk("cnt_after_12", 12'(cnt_val), 12'd3);

        // Pause with phase 2, lap ignored, resume.
        for (int i = 0; i < 8 && (m_runs % P) != 2; i++)
            tick();
        start_stop = 1'b1;
        tick();
        start_stop = 1'b0;
        repeat (4) tick();
        lap = 1'b1;
        tick();
        lap = 1'b0;
        repeat (5) tick();
        #1 chk("lap_in_pause", 12'(hold), 12'd0);
        start_stop = 1'b1;
        tick();
        start_stop = 1'b0;
        #1 chk("resume_tick", 12'(cnt_en), 12'd1);
        tick();

        // Lap toggles hold while ticks continue.
        lap = 1'b1;
        tick();
        lap = 1'b0;
        #1 chk("lap_on", 12'(hold), 12'd1);
        e0 = en_count;
        repeat (8) tick();
        chk("ticks_in_lap", 12'(en_count - e0), 12'd2);
        lap = 1'b1;
        tick();
        lap = 1'b0;
        #1 chk("lap_off", 12'(hold), 12'd0);
        lap = 1'b1;
        tick();
        lap = 1'b0;
        tick();

        // Clear and start_stop together in RUN.
        clear = 1'b1;
        start_stop = 1'b1;
        tick();
        clear = 1'b0;
        start_stop = 1'b0;
        #1 chk("clr_ss_state", 12'(state), 12'd0);
        chk("clr_pulse", 12'(cnt_clr), 12'd1);
        chk("clr_hold", 12'(hold), 12'd0);
        tick();
        #1 chk("clr_single", 12'(cnt_clr), 12'd0);
        chk("cnt_cleared", 12'(cnt_val), 12'd0);

        // Limit 005: five ticks then DONE.
        limit = 12'h005;
        limit_en = 1'b1;
        en_count = 0;
        press_ss();
        for (int i = 0; i < 40 && state != 2'd3; i++)
            tick();
        #1 chk("done_reached", 12'(state), 12'd3);
        chk("limit_ticks", 12'(en_count), 12'd5);
        chk("limit_cnt", 12'(cnt_val), 12'd5);
        chk("limit_alarm", 12'(alarm), 12'd1);
        repeat (6) tick();
        chk("no_6th_tick", 12'(en_count), 12'd5);
        press_ss();
        #1 chk("done_exit", 12'(state), 12'd0);

        // Limit 000: DONE one edge after RUN, no ticks.
        limit = 12'h000;
        en_count = 0;
        press_ss();
        #1 chk("lim0_done", 12'(state), 12'd3);
        chk("lim0_ticks", 12'(en_count), 12'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        limit_en = 1'b0;

        // Reset mid-RUN with hold set.
        press_ss();
        lap = 1'b1;
        tick();
        lap = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        #1 chk("rst_state", 12'(state), 12'd0);
        chk("rst_hold", 12'(hold), 12'd0);
        chk("rst_clr", 12'(cnt_clr), 12'd0);
        chk("rst_en", 12'(cnt_en), 12'd0);
        reset = 1'b0;
        tick();

        // Random buttons, limits and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0)
                start_stop = ~start_stop;
            if ($urandom_range(0, 30) == 0)
                clear = ~clear;
            if ($urandom_range(0, 7) == 0)
                lap = ~lap;
            if ($urandom_range(0, 60) == 0) begin
                limit_en = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 4) == 0)
                    limit = 12'h0A3;
                else
                    limit = to_bcd($urandom_range(0, 12));
            end
            reset = ($urandom_range(0, 250) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
